window3x3_ctrl: RTL

Controller that sequences the 3x3 pixel-window datapath: three 72-bit row shift registers (3 x 24-bit RGB pixels each) fed by two line buffers of IMG_WIDTH entries.
- Accepts a raster-order pixel stream with valid/ready.
- Tracks column/row position and drives shift enables and line-buffer write/address.
- Flags when the three shift registers hold a complete 3x3 neighbourhood; sits between the pixel source and the grayscale/filter stage.

---
 rtl/window3x3_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/window3x3_ctrl.sv
// window3x3_ctrl: sequences a 3x3 pixel-window datapath (three row shift
// registers fed by two line buffers) from a raster-order pixel stream.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a frame (honoured only in IDLE)
//   pixel_valid         source presents a pixel
//   pixel_ready         controller can take a pixel (FILL/RUN)
//   shift_en, lb_wr_en  shift/write strobes, asserted on every accepted pixel
//   lb_addr             line-buffer address (= current column)
//   window_valid        registered: shift registers hold a full 3x3 window
//   win_col, win_row    centre of the window flagged by window_valid
//   busy                frame in progress
//   frame_done          registered one-cycle end-of-frame pulse
module window3x3_ctrl #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned COL_W      = 10,
  parameter int unsigned ROW_W      = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pixel_valid,
  output logic             pixel_ready,
  output logic             shift_en,
  output logic             lb_wr_en,
  output logic [COL_W-1:0] lb_addr,
  output logic             window_valid,
  output logic [COL_W-1:0] win_col,
  output logic [ROW_W-1:0] win_row,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             accept;
  logic             col_last;
  logic             win_hit;
  logic             frame_end;

  // State and position registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Next-state, counter advance and handshake decode
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    pixel_ready = 1'b0;
    busy        = 1'b0;

    if (state_q == S_FILL || state_q == S_RUN) begin
      pixel_ready = 1'b1;
      busy        = 1'b1;
    end

    accept    = pixel_valid & pixel_ready;
    col_last  = (col_q == COL_LAST);
    // Windows need two full rows above and two columns to the left.
    win_hit   = accept && (col_q >= COL_TWO) && (row_q >= ROW_TWO);
    frame_end = accept && col_last && (row_q == ROW_LAST) && (state_q == S_RUN);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_FILL: begin
        if (accept) begin
          if (col_last) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
            if (row_q == ROW_ONE) state_d = S_RUN;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          if (col_last) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = S_DONE;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign shift_en = accept;
  assign lb_wr_en = accept;
  assign lb_addr  = col_q;

  // Window flag and centre, one cycle behind the accepting pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      window_valid <= 1'b0;
      win_col      <= '0;
      win_row      <= '0;
      frame_done   <= 1'b0;
    end else begin
      window_valid <= win_hit;
      frame_done   <= frame_end;
      if (win_hit) begin
        win_col <= col_q - COL_W'(1);
        win_row <= row_q - ROW_W'(1);
      end
    end
  end

endmodule
